uart_rx: RTL and testbench

- Simple UART receiver, companion to the UART transmitter on the same memory-mapped bus.
- Deserialises 8N1 frames from an asynchronous serial input, with the bit period matched to the transmitter's.
- Queues received bytes in a small FIFO.
- Exposes data and status registers to the CPU through the shared picorv32-style mem_* bus, with tri-stated outputs when not selected.

---
 rtl/uart_rx.sv | 178 +++++++++++++++++
 tb/tb_uart_rx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small byte FIFO behind
// a two-register picorv32-style memory-mapped interface.
module uart_rx #(
  parameter int BAUD_DIVIDER = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_instr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  input  logic        serialIn
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW =
    ($clog2(BAUD_DIVIDER + 1) > 20) ?
    $clog2(BAUD_DIVIDER + 1) : 20;
  localparam logic [TW-1:0] T_BIT  = TW'(BAUD_DIVIDER);
  localparam logic [TW-1:0] T_HALF = TW'(BAUD_DIVIDER / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t        state, state_n;
  logic          sync1, rx_s;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          push, fe_set, tick;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wp, rp;
  logic          empty, full, pop, do_push;
  logic [7:0]    head;

  logic          rdy, accept, is_stat, is_wr, clr;
  logic          ovr, fe;
  logic [31:0]   rdata_reg, rd_val;

  logic unused_bits;
  assign unused_bits = ^{mem_instr, mem_wdata,
                         mem_addr[31:3], mem_addr[1:0]};

  assign tick = (timer == '0);

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    push      = 1'b0;
    fe_set    = 1'b0;
    if (state != S_IDLE && state != S_BREAK)
      timer_n = tick ? T_BIT : timer - TW'(1);
    unique case (state)
      S_IDLE: begin
        if (!rx_s) begin
          timer_n = T_HALF;
          state_n = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (!rx_s) begin
            bit_cnt_n = '0;
            state_n   = S_DATA;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_n   = {rx_s, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            push    = 1'b1;
            state_n = S_IDLE;
          end else begin
            fe_set  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = fifo_mem[rp[AW-1:0]];

  assign accept  = mem_valid & enable & ~rdy;
  assign is_stat = mem_addr[2];
  assign is_wr   = |mem_wstrb;
  assign pop     = accept & ~is_stat & ~is_wr & ~empty;
  assign do_push = push & ~full;
  assign clr     = accept & is_stat & mem_wstrb[0];

  always_comb begin
    rd_val = '0;
    if (is_stat)
      rd_val[3:0] = {fe, ovr, full, ~empty};
    else if (!empty)
      rd_val[7:0] = head;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      state     <= S_IDLE;
      timer     <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      wp        <= '0;
      rp        <= '0;
      ovr       <= 1'b0;
      fe        <= 1'b0;
      rdy       <= 1'b0;
      rdata_reg <= '0;
    end else begin
      sync1   <= serialIn;
      rx_s    <= sync1;
      state   <= state_n;
      timer   <= timer_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
      if (do_push)
        wp <= wp + (AW+1)'(1);
      if (pop)
        rp <= rp + (AW+1)'(1);
      // a flag raised in the same cycle as a clear survives
      if (push && full)
        ovr <= 1'b1;
      else if (clr)
        ovr <= 1'b0;
      if (fe_set)
        fe <= 1'b1;
      else if (clr)
        fe <= 1'b0;
      rdy <= accept;
      if (accept)
        rdata_reg <= rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      fifo_mem[wp[AW-1:0]] <= shift;
  end

  assign mem_ready = enable ? rdy : 1'bz;
  assign mem_rdata = enable ? rdata_reg : 32'bz;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bench for uart_rx with a queue-based model of
// the received byte stream and sticky status flags.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DIV   = 15;
  localparam int BIT   = DIV + 1;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        mem_valid;
  logic        mem_instr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        serialIn;
  tri1         mem_ready;
  tri1  [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [7:0] q [$];
  logic       m_ovr, m_fe;

  uart_rx #(
    .BAUD_DIVIDER(DIV),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_instr(mem_instr),
    .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .serialIn (serialIn)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        stop;
    logic [31:0] st;
    logic [31:0] dat;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_stat();
    return {28'h0, m_fe, m_ovr,
            q.size() == DEPTH, q.size() != 0};
  endfunction

  task automatic m_reset();
    q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic line_bit(input logic b, input int n);
    serialIn = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    @(negedge clk);
    line_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++)
      line_bit(d[i], BIT);
    line_bit(stop, BIT);
    line_bit(1'b1, 4);
    if (!stop)
      m_fe = 1'b1;
    else if (q.size() == DEPTH)
      m_ovr = 1'b1;
    else
      q.push_back(d);
  endtask

  task automatic bus(input logic a2,
                     input logic [3:0] ws,
                     input logic [31:0] wd,
                     output logic [31:0] rd);
    int n;
    @(negedge clk);
    mem_valid   = 1'b1;
    mem_addr    = $urandom;
    mem_addr[2] = a2;
    mem_wstrb   = ws;
    mem_wdata   = wd;
    mem_instr   = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (mem_ready !== 1'b1 && n < 8);
    chk("bus_ack", {31'h0, mem_ready}, 32'h1);
    rd = mem_rdata;
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  task automatic rd_stat(input string nm, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b1, 4'h0, 32'h0, r);
    chk(nm, r, exp);
  endtask

  task automatic rd_dat(input string nm, input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, 4'h0, 32'h0, r);
    chk(nm, r, exp);
  endtask

  task automatic clr_stat();
    logic [31:0] r;
    bus(1'b1, 4'h1, $urandom, r);
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    m_reset();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [6];
    logic [31:0] r, rc, exp;
    logic [7:0]  d;
    logic        stop;

    tbl[0] = '{8'hA5, 1'b1, 32'h1, 32'hA5};
    tbl[1] = '{8'h55, 1'b1, 32'h1, 32'h55};
    tbl[2] = '{8'h0F, 1'b1, 32'h1, 32'h0F};
    tbl[3] = '{8'h00, 1'b1, 32'h1, 32'h00};
    tbl[4] = '{8'hFF, 1'b1, 32'h1, 32'hFF};
    tbl[5] = '{8'h3C, 1'b0, 32'h8, 32'h00};

    resetn    = 1'b0;
    enable    = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'h0;
    mem_addr  = 32'h0;
    serialIn  = 1'b1;
    m_reset();

    #1;
    chk("hiz_ready", {31'h0, mem_ready}, 32'h1);
    chk("hiz_rdata", mem_rdata, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    enable = 1'b1;
    #1;
    chk("rst_ready", {31'h0, mem_ready}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);

    // valid held across two cycles yields one ready pulse
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h4;
    mem_wstrb = 4'h0;
    @(posedge clk);
    #1;
    chk("pulse_c1", {31'h0, mem_ready}, 32'h1);
    chk("idle_stat", mem_rdata, 32'h0);
    @(posedge clk);
    #1;
    chk("pulse_c2", {31'h0, mem_ready}, 32'h0);
    @(negedge clk);
    mem_valid = 1'b0;
    enable    = 1'b0;
    #1;
    chk("hiz2_ready", {31'h0, mem_ready}, 32'h1);
    chk("hiz2_rdata", mem_rdata, 32'hFFFF_FFFF);
    enable = 1'b1;

    bus(1'b0, 4'hF, 32'h0000_00AA, r);
    rd_stat("wr_data_ign", 32'h0);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, tbl[i].stop);
      rd_stat($sformatf("tbl%0d_stat", i), tbl[i].st);
      rd_dat($sformatf("tbl%0d_data", i), tbl[i].dat);
      clr_stat();
      rd_stat($sformatf("tbl%0d_clr", i), 32'h0);
    end

    send(8'h55, 1'b1);
    send(8'h0F, 1'b1);
    rd_dat("loop_0", 32'h55);
    rd_dat("loop_1", 32'h0F);

    for (int i = 1; i <= 5; i++)
      send(8'(i), 1'b1);
    rd_stat("ovr_stat", 32'h7);
    for (int i = 1; i <= 4; i++)
      rd_dat($sformatf("ovr_rd%0d", i), 32'(i));
    rd_dat("ovr_empty", 32'h0);
    rd_stat("ovr_sticky", 32'h4);
    clr_stat();
    rd_stat("ovr_clr", 32'h0);
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      send(d, 1'b1);
      rd_dat($sformatf("wrap%0d", i), {24'h0, d});
    end

    @(negedge clk);
    line_bit(1'b0, BIT);
    for (int i = 0; i < 8; i++)
      line_bit(tbl[5].d[i], BIT);
    line_bit(1'b0, 31 * BIT);
    line_bit(1'b1, 2 * BIT);
    rd_stat("brk_stat", 32'h8);
    rd_dat("brk_empty", 32'h0);
    send(8'h3C, 1'b1);
    rd_stat("brk_after", 32'h9);
    rd_dat("brk_data", 32'h3C);
    clr_stat();
    rd_stat("brk_clr", 32'h0);

    @(negedge clk);
    line_bit(1'b0, 3);
    line_bit(1'b1, 2 * BIT);
    rd_stat("glitch_stat", 32'h0);
    rd_dat("glitch_data", 32'h0);

    // DATA read lands on the stop-bit sample of the next frame
    send(8'h11, 1'b1);
    fork
      send(8'h77, 1'b1);
      begin
        @(negedge clk);
        repeat (153) @(negedge clk);
        bus(1'b0, 4'h0, 32'h0, rc);
        chk("coin_rd", rc, 32'h11);
      end
    join
    rd_stat("coin_stat", 32'h1);
    rd_dat("coin_rd2", 32'h77);
    rd_stat("coin_empty", 32'h0);

    send(8'h22, 1'b1);
    rd_stat("mid_pre", 32'h1);
    @(negedge clk);
    line_bit(1'b0, BIT);
    line_bit(1'b1, BIT);
    line_bit(1'b0, BIT + 5);
    do_reset();
    line_bit(1'b1, 12 * BIT);
    rd_stat("mid_rst", 32'h0);
    send(8'hC3, 1'b1);
    rd_stat("mid_stat", 32'h1);
    rd_dat("mid_data", 32'hC3);

    do_reset();
    for (int i = 0; i < 28; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      send(d, stop);
      if ($urandom_range(0, 3) == 0)
        rd_stat($sformatf("rnd_stat%0d", i), m_stat());
      if ($urandom_range(0, 1) == 1) begin
        exp = 32'h0;
        if (q.size() != 0)
          exp = {24'h0, q.pop_front()};
        rd_dat($sformatf("rnd_data%0d", i), exp);
      end
      if ($urandom_range(0, 5) == 0)
        clr_stat();
      if ($urandom_range(0, 7) == 0)
        bus(1'b0, 4'hF, $urandom, r);
    end
    rd_stat("rnd_final_stat", m_stat());
    for (int i = 0; i <= DEPTH; i++) begin
      exp = 32'h0;
      if (q.size() != 0)
        exp = {24'h0, q.pop_front()};
      rd_dat($sformatf("rnd_drain%0d", i), exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
